// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: bus-master sequencer for the HV PWM register block.
// Programs period, t[0] and control over the 16-bit register bus, soft-start
// ramps t[0] from a start value to a target, holds, and shuts the generator
// down on stop or the limit switch.
// Optional feature macro: PWM_RAMP_DOWN_EN (stop in WAIT/HOLD ramps t[0]
// back down to the start value before the disable write).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; busy=0
// CFG     | five configuration writes on the bus (idx = word on the bus)
// WAIT    | interval countdown before the next ramp-up step
// UPD     | t[0] lo/hi write of the new ramp-up value
// HOLD    | target reached; done=1, waiting for stop/ls
// OFF     | disable control write on the bus; IDLE next
// DWAIT   | interval countdown before the next ramp-down step
// DUPD    | t[0] lo/hi write of the new ramp-down value
module pwm_ramp_ctrl #(
    parameter logic [15:0] BAR = 16'h0000,
    parameter int          W   = 32
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          start,
    input  logic          stop,
    input  logic          ls,
    input  logic [W-1:0]  per,
    input  logic [W-1:0]  t_start,
    input  logic [W-1:0]  t_target,
    input  logic [W-1:0]  t_step,
    input  logic [W-1:0]  interval,
    input  logic [3:0]    hv_code_in,
    input  logic          inv,
    output logic [15:0]   addr,
    output logic [1:0]    be,
    output logic          write,
    output logic [15:0]   wrdata,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CFG   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_UPD   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_OFF   = 3'd5;
`ifdef PWM_RAMP_DOWN_EN
    localparam logic [2:0] S_DWAIT = 3'd6;
    localparam logic [2:0] S_DUPD  = 3'd7;
`endif

    localparam logic [15:0] A_PER_LO = BAR;
    localparam logic [15:0] A_PER_HI = BAR + 16'h0002;
    localparam logic [15:0] A_T0_LO  = BAR + 16'h0004;
    localparam logic [15:0] A_T0_HI  = BAR + 16'h0006;
    localparam logic [15:0] A_CTRL   = BAR + 16'h000C;

    logic [2:0]   state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] per_q, per_d;
    logic [W-1:0] cur_q, cur_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic [W-1:0] step_q, step_d;
    logic [W-1:0] ival_q, ival_d;
    logic [3:0]   hv_q, hv_d;
    logic         inv_q, inv_d;
    logic         busy_q, busy_d;
    logic         fault_q, fault_d;
    logic         done_q, done_d;
    logic [15:0]  addr_q, addr_d;
    logic [1:0]   be_q, be_d;
    logic         write_q, write_d;
    logic [15:0]  wrdata_q, wrdata_d;
`ifdef PWM_RAMP_DOWN_EN
    logic [W-1:0] tst_q, tst_d;
    logic [W-1:0] dn_next;
    logic         stop_dn;
`endif

    logic [W:0]   sum;
    logic [W-1:0] up_next;
    logic         stop_off;
    logic         go_off;
    logic         emit;
    logic [15:0]  emit_addr, emit_data;
    logic [15:0]  ctrl_on, ctrl_off;

    // Next-state, datapath and next bus word; outputs are the registered copy.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        step_d    = step_q;
        ival_d    = ival_q;
        hv_d      = hv_q;
        inv_d     = inv_q;
        busy_d    = busy_q;
        fault_d   = fault_q;
        done_d    = 1'b0;
        go_off    = 1'b0;
        emit      = 1'b0;
        emit_addr = addr_q;
        emit_data = wrdata_q;
        ctrl_on   = {6'h00, inv_q, 1'b1, 4'h0, hv_q};
        ctrl_off  = {6'h00, inv_q, 1'b0, 4'h0, 4'h0};

        // 33-bit sum so a large step saturates at the target instead of wrapping
        sum     = {1'b0, cur_q} + {1'b0, t_step_sel(step_q)};
        up_next = (step_q == '0 || sum >= {1'b0, tgt_q}) ? tgt_q : sum[W-1:0];

`ifdef PWM_RAMP_DOWN_EN
        tst_d    = tst_q;
        // only used while cur > t_start, so cur - tst cannot underflow
        dn_next  = (step_q == '0 || (cur_q - tst_q) <= step_q) ? tst_q : cur_q - step_q;
        stop_dn  = stop && (state_q == S_WAIT || state_q == S_HOLD) && (cur_q > tst_q);
        stop_off = stop && (state_q == S_CFG || state_q == S_UPD ||
                            ((state_q == S_WAIT || state_q == S_HOLD) && cur_q <= tst_q));
`else
        stop_off = stop;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ls) begin
                        fault_d = 1'b1;
                    end else begin
                        per_d     = per;
                        tgt_d     = t_target;
                        cur_d     = (t_start < t_target) ? t_start : t_target;
                        step_d    = t_step;
                        ival_d    = (interval == '0) ? W'(1) : interval;
                        hv_d      = hv_code_in;
                        inv_d     = inv;
`ifdef PWM_RAMP_DOWN_EN
                        tst_d     = t_start;
`endif
                        fault_d   = 1'b0;
                        busy_d    = 1'b1;
                        idx_d     = 3'd0;
                        state_d   = S_CFG;
                        emit      = 1'b1;
                        emit_addr = A_PER_LO;
                        emit_data = per[15:0];
                    end
                end
            end
            S_OFF: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                if (ls) begin
                    go_off  = 1'b1;
                    fault_d = 1'b1;
                end else if (stop_off) begin
                    go_off = 1'b1;
`ifdef PWM_RAMP_DOWN_EN
                end else if (stop_dn) begin
                    state_d = S_DWAIT;
                    cnt_d   = ival_q;
`endif
                end else begin
                    case (state_q)
                        S_CFG: begin
                            if (idx_q == 3'd4) begin
                                if (cur_q == tgt_q) begin
                                    state_d = S_HOLD;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = S_WAIT;
                                    cnt_d   = ival_q;
                                end
                            end else begin
                                idx_d = idx_q + 3'd1;
                                emit  = 1'b1;
                                case (idx_q)
                                    3'd0:    begin emit_addr = A_PER_HI; emit_data = per_q[31:16]; end
                                    3'd1:    begin emit_addr = A_T0_LO;  emit_data = cur_q[15:0];  end
                                    3'd2:    begin emit_addr = A_T0_HI;  emit_data = cur_q[31:16]; end
                                    default: begin emit_addr = A_CTRL;   emit_data = ctrl_on;      end
                                endcase
                            end
                        end
                        S_WAIT: begin
                            if (cnt_q == W'(1)) begin
                                cur_d     = up_next;
                                idx_d     = 3'd0;
                                state_d   = S_UPD;
                                emit      = 1'b1;
                                emit_addr = A_T0_LO;
                                emit_data = up_next[15:0];
                            end else begin
                                cnt_d = cnt_q - W'(1);
                            end
                        end
                        S_UPD: begin
                            if (idx_q == 3'd0) begin
                                idx_d     = 3'd1;
                                emit      = 1'b1;
                                emit_addr = A_T0_HI;
                                emit_data = cur_q[31:16];
                            end else if (cur_q == tgt_q) begin
                                state_d = S_HOLD;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                                cnt_d   = ival_q;
                            end
                        end
                        S_HOLD: begin
                            done_d = 1'b1;
                        end
`ifdef PWM_RAMP_DOWN_EN
                        S_DWAIT: begin
                            if (cnt_q == W'(1)) begin
                                cur_d     = dn_next;
                                idx_d     = 3'd0;
                                state_d   = S_DUPD;
                                emit      = 1'b1;
                                emit_addr = A_T0_LO;
                                emit_data = dn_next[15:0];
                            end else begin
                                cnt_d = cnt_q - W'(1);
                            end
                        end
                        S_DUPD: begin
                            if (idx_q == 3'd0) begin
                                idx_d     = 3'd1;
                                emit      = 1'b1;
                                emit_addr = A_T0_HI;
                                emit_data = cur_q[31:16];
                            end else if (cur_q == tst_q) begin
                                go_off = 1'b1;
                            end else begin
                                state_d = S_DWAIT;
                                cnt_d   = ival_q;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        endcase

        if (go_off) begin
            state_d   = S_OFF;
            emit      = 1'b1;
            emit_addr = A_CTRL;
            emit_data = ctrl_off;
        end

        write_d  = emit;
        be_d     = emit ? 2'b11 : 2'b00;
        addr_d   = emit_addr;
        wrdata_d = emit_data;
    end

    // Identity helper keeps the step operand width explicit in the 33-bit sum.
    function automatic logic [W-1:0] t_step_sel(input logic [W-1:0] s);
        return s;
    endfunction

    // State, latched configuration and registered bus outputs.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            per_q    <= '0;
            cur_q    <= '0;
            tgt_q    <= '0;
            step_q   <= '0;
            ival_q   <= '0;
            hv_q     <= '0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            write_q  <= 1'b0;
            wrdata_q <= '0;
`ifdef PWM_RAMP_DOWN_EN
            tst_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            step_q   <= step_d;
            ival_q   <= ival_d;
            hv_q     <= hv_d;
            inv_q    <= inv_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            write_q  <= write_d;
            wrdata_q <= wrdata_d;
`ifdef PWM_RAMP_DOWN_EN
            tst_q    <= tst_d;
`endif
        end
    end

    assign addr   = addr_q;
    assign be     = be_q;
    assign write  = write_q;
    assign wrdata = wrdata_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl: table vectors, randomized ramps against a
// cycle-level write-list model, and hand sequences for the shutdown cases.
module tb_pwm_ramp_ctrl;

    localparam logic [15:0] BAR = 16'h4000;

    logic        clk = 1'b0;
    logic        aclr_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, ls = 1'b0;
    logic [31:0] per = '0, t_start = '0, t_target = '0, t_step = '0, interval = '0;
    logic [3:0]  hv_code_in = '0;
    logic        inv = 1'b0;
    logic [15:0] addr, wrdata;
    logic [1:0]  be;
    logic        write, busy, done, fault;

    pwm_ramp_ctrl #(.BAR(BAR), .W(32)) dut (
        .clk(clk), .aclr_n(aclr_n), .start(start), .stop(stop), .ls(ls),
        .per(per), .t_start(t_start), .t_target(t_target), .t_step(t_step),
        .interval(interval), .hv_code_in(hv_code_in), .inv(inv),
        .addr(addr), .be(be), .write(write), .wrdata(wrdata),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  b;
    } wr_t;

    typedef struct {
        logic [31:0] per, ts, tt, step, iv;
        logic [3:0]  hv;
        logic        inv;
        logic [31:0] fin;
        int          nupd;
    } vec_t;

    wr_t got[$];
    wr_t exp_q[$];
    vec_t tbl[6];

    always @(negedge clk) if (write) got.push_back('{cyc, addr, wrdata, be});

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [63:0] pk(input wr_t w);
        return {14'h0, w.c[15:0], w.a, w.d, w.b};
    endfunction

    task automatic push(input int c, input logic [15:0] off, input logic [15:0] d);
        exp_q.push_back('{c, BAR + off, d, 2'b11});
    endtask

    // Expected CFG + ramp-up write list for a start seen in cycle s.
    task automatic model_up(input vec_t v, input int s, output int done_c, output logic [63:0] fin_m);
        logic [63:0] cur, tgt, step;
        int t, iv;
        iv   = (v.iv == 0) ? 1 : int'(v.iv);
        tgt  = {32'h0, v.tt};
        step = {32'h0, v.step};
        cur  = (v.ts < v.tt) ? {32'h0, v.ts} : tgt;
        push(s + 1, 16'h0, v.per[15:0]);
        push(s + 2, 16'h2, v.per[31:16]);
        push(s + 3, 16'h4, cur[15:0]);
        push(s + 4, 16'h6, cur[31:16]);
        push(s + 5, 16'hC, 16'h0100 | (v.inv ? 16'h0200 : 16'h0) | {12'h0, v.hv});
        t = s + 5;
        while (cur != tgt) begin
            t += iv + 1;
            if (step == 0 || cur + step > tgt) cur = tgt;
            else cur = cur + step;
            push(t, 16'h4, cur[15:0]);
            push(t + 1, 16'h6, cur[31:16]);
            t++;
        end
        done_c = t + 1;
        fin_m  = cur;
    endtask

    // Expected shutdown writes after a stop seen in HOLD in cycle x.
    task automatic model_stop(input vec_t v, input logic [63:0] cur_in, input int x, output int busy_c);
        int t;
        logic [63:0] cur, ts;
        cur = cur_in;
        ts  = {32'h0, v.ts};
        t   = x;
`ifdef PWM_RAMP_DOWN_EN
        while (cur > ts) begin
            t += ((v.iv == 0) ? 1 : int'(v.iv)) + 1;
            if (v.step == 0 || cur < ts + {32'h0, v.step}) cur = ts;
            else cur = cur - {32'h0, v.step};
            push(t, 16'h4, cur[15:0]);
            push(t + 1, 16'h6, cur[31:16]);
            t++;
        end
`endif
        push(t + 1, 16'hC, v.inv ? 16'h0200 : 16'h0000);
        busy_c = t + 2;
    endtask

    task automatic compare_logs(input string name);
        check({name, "_nwrites"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_wr%0d", name, i), pk(got[i]), pk(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic drive_cfg(input vec_t v);
        per = v.per; t_start = v.ts; t_target = v.tt; t_step = v.step;
        interval = v.iv; hv_code_in = v.hv; inv = v.inv;
    endtask

    // Full run: start, wait for done, stop, wait for idle, compare writes.
    task automatic run_full(input vec_t v, input string name);
        int s, d, x, b, done_c, busy_c, n, lo_i, hi_i, nlo;
        logic [63:0] fin_m;
        drive_cfg(v);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_up(v, s, done_c, fin_m);
        n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        d = cyc;
        check({name, "_done_cyc"}, 64'(d - s), 64'(done_c - s));
        check({name, "_fault_clear"}, 64'(fault), 64'(0));
        if (v.nupd >= 0) begin
            lo_i = -1; hi_i = -1; nlo = 0;
            for (int i = 0; i < got.size(); i++) begin
                if (got[i].a == BAR + 16'h4) begin lo_i = i; nlo++; end
                if (got[i].a == BAR + 16'h6) hi_i = i;
            end
            if (lo_i >= 0 && hi_i >= 0)
                check({name, "_final_t0"}, 64'({got[hi_i].d, got[lo_i].d}), 64'(v.fin));
            else
                check({name, "_final_t0"}, 64'hDEAD, 64'(v.fin));
            check({name, "_nupd"}, 64'(nlo - 1), 64'(v.nupd));
        end
        x = cyc;
        stop = 1'b1;
        model_stop(v, fin_m, x, busy_c);
        @(negedge clk);
        stop = 1'b0;
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        b = cyc;
        check({name, "_busy_drop"}, 64'(b - x), 64'(busy_c - x));
        compare_logs(name);
    endtask

    initial begin
        int s, dc;
        logic [63:0] fm;
        vec_t v;
        logic [63:0] diff;

        tbl[0] = '{32'd1000, 32'd100, 32'd400, 32'd100, 32'd10, 4'h5, 1'b0, 32'd400, 3};
        tbl[1] = '{32'd2000, 32'd500, 32'd300, 32'd50, 32'd3, 4'hA, 1'b1, 32'd300, 0};
        tbl[2] = '{32'd1234, 32'd100, 32'd600, 32'd250, 32'd2, 4'h3, 1'b0, 32'd600, 2};
        tbl[3] = '{32'h0001_0005, 32'hFFFF_FFC0, 32'hFFFF_FFF0, 32'h20, 32'd1, 4'hF, 1'b1, 32'hFFFF_FFF0, 2};
        tbl[4] = '{32'd77, 32'd0, 32'd3, 32'd1, 32'd0, 4'h1, 1'b0, 32'd3, 3};
        tbl[5] = '{32'd500, 32'd10, 32'd50, 32'd0, 32'd4, 4'h2, 1'b1, 32'd50, 1};

        // reset values
        repeat (3) @(negedge clk);
        check("reset_outputs", {26'h0, addr, be, write, wrdata, busy, done, fault}, 64'h0);
        aclr_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));

        for (int i = 0; i < 6; i++) run_full(tbl[i], $sformatf("tbl%0d", i));

        // randomized ramps
        for (int k = 0; k < 8; k++) begin
            v.per = $urandom;
            if (k % 2 == 0) begin
                v.ts = $urandom_range(0, 2000);
                v.tt = $urandom_range(0, 2000);
            end else begin
                v.ts = $urandom;
                v.tt = $urandom;
            end
            diff = (v.tt > v.ts) ? 64'(v.tt - v.ts) : 64'(v.ts - v.tt);
            if ($urandom_range(0, 3) == 0) v.step = 0;
            else begin
                diff = diff / 64'($urandom_range(1, 6)) + 64'($urandom_range(0, 3));
                v.step = (diff > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : diff[31:0];
            end
            v.iv   = $urandom_range(0, 6);
            v.hv   = 4'($urandom);
            v.inv  = 1'($urandom);
            v.fin  = '0;
            v.nupd = -1;
            run_full(v, $sformatf("rnd%0d", k));
        end

        // limit switch during WAIT: abrupt OFF, fault set
        drive_cfg(tbl[0]);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_up(tbl[0], s, dc, fm);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        repeat (7) @(negedge clk);
        ls = 1'b1;
        push(s + 9, 16'hC, 16'h0000);
        @(negedge clk);
        ls = 1'b0;
        check("ls_wait_fault", 64'(fault), 64'(1));
        check("ls_wait_busy_off", 64'(busy), 64'(1));
        @(negedge clk);
        check("ls_wait_idle", 64'(busy), 64'(0));
        compare_logs("ls_wait");
        run_full(tbl[1], "after_ls");

        // stop during CFG after the second write
        drive_cfg(tbl[2]);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_up(tbl[2], s, dc, fm);
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        @(negedge clk);
        stop = 1'b1;
        push(s + 3, 16'hC, 16'h0000);
        @(negedge clk);
        stop = 1'b0;
        check("stop_cfg_busy1", 64'(busy), 64'(1));
        @(negedge clk);
        check("stop_cfg_busy0", 64'(busy), 64'(0));
        check("stop_cfg_nofault", 64'(fault), 64'(0));
        compare_logs("stop_cfg");

        // ls in IDLE blocks start and sets fault
        ls = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ls = 1'b0;
        check("ls_idle_fault", 64'(fault), 64'(1));
        check("ls_idle_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("ls_idle_nowrite", 64'(got.size()), 64'(0));
        got.delete();
        run_full(tbl[4], "after_ls_idle");

        // asynchronous reset mid-sequence
        drive_cfg(tbl[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        aclr_n = 1'b0;
        #1;
        check("areset_mid", {61'h0, write, busy, done}, 64'h0);
        @(negedge clk);
        aclr_n = 1'b1;
        got.delete();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Bus-master sequencer for the HV PWM register block.
- On start, it programs period, first-phase duty and control (enable, hv_code, inv) through the 16-bit register bus.
- It then ramps duty t[0] from a start value to a target in fixed steps at a programmed interval (soft-start), and holds.
- Limit switch or stop disables the generator through the same bus. It sits between the CPU-side configuration registers and the PWM register block.

Parameters:
- BAR, 'h0, base address of the PWM register block; offsets +0/+2 per lo/hi, +4/+6 t[0] lo/hi, +C control.
- W, 32, width of per/t/step/interval values. Bus words are 16 bits; W is fixed at 32.

Ports:
- clk  in  1  system clock
- aclr_n  in  1  asynchronous reset, active-low
- start  in  1  1-cycle pulse; begin sequence (ignored unless IDLE)
- stop  in  1  1-cycle pulse; shut down (ignored in IDLE)
- ls  in  1  limit switch, level; forces shutdown
- per  in  32  PWM period, latched at start
- t_start  in  32  initial t[0], latched at start
- t_target  in  32  final t[0], latched at start
- t_step  in  32  ramp increment, latched at start
- interval  in  32  clocks between ramp updates, latched at start
- hv_code_in  in  4  hv_code written with enable
- inv  in  1  output inversion bit written with enable
- addr  out  16  bus address
- be  out  2  byte enables
- write  out  1  bus write strobe, 1 cycle per word
- wrdata  out  16  bus write data
- busy  out  1  high in every state except IDLE
- done  out  1  high in HOLD
- fault  out  1  sticky; set when ls causes shutdown, cleared by next accepted start

Behaviour:
- All outputs are registered. Reset values: addr=0, be=0, write=0, wrdata=0, busy=0, done=0, fault=0. State resets to IDLE.
- Every bus write is one cycle with be=2'b11. Consecutive writes are back-to-back; there is no wait/ack.
- Control word: {6'h0, inv, ena, 4'h0, hv_code}.
- IDLE: start latches all inputs.
  - cur = min(t_start, t_target).
  - interval of 0 is treated as 1.
  - Go to CFG.
- CFG: five writes in this order: per lo, per hi, cur lo, cur hi, control (ena=1, hv_code_in, inv).
  - The first write appears the cycle after start (latency 1).
  - After the control write: if cur==target go to HOLD, else go to WAIT.
- WAIT: counter loads interval and counts down to 1, then goes to UPD.
- UPD:
  - cur = min(cur+step, target), computed 33-bit, so no wrap.
  - If step==0, cur=target.
  - Write cur lo then cur hi on consecutive cycles.
  - Then go to HOLD if cur==target, else WAIT.
- HOLD: done=1; no writes; wait for stop or ls.
- OFF:
  - One control write with ena=0, hv_code=0, inv=latched inv.
  - Next cycle: IDLE, busy=0.
- Shutdown triggers:
  - ls=1 in any non-IDLE state → OFF next cycle. An in-flight single write already on the bus completes; the remaining CFG/UPD writes are abandoned. Sets fault.
  - stop: same as ls, but does not set fault.
  - ls and stop in the same cycle: treated as ls.
- ls=1 in IDLE blocks start: start is ignored and fault is set.
- start while busy is ignored. stop in IDLE is ignored.
- An asynchronous reset mid-sequence returns to IDLE immediately with write=0. No disable write is issued; the PWM block is reset by its own reset.

Optional Feature:
- Macro: PWM_RAMP_DOWN_EN.
- Defined:
  - stop in WAIT or HOLD enters a RAMP_DN path: cur = max(cur−step, t_start), saturating at t_start.
  - Each update is written lo/hi, spaced by interval, as in UPD.
  - When cur==t_start, go to OFF. stop during RAMP_DN is ignored.
  - ls always goes directly to OFF (abrupt).
- Not defined: stop goes directly to OFF, as above.

Test Plan:
- Reset, then start with per=1000, t_start=100, t_target=400, t_step=100, interval=10:
  - Writes BAR+0=1000, +2=0, +4=100, +6=0, +C=0x01xx.
  - Then t[0] lo writes of 200, 300, 400, each 10+2 cycles apart.
  - done=1 after 400.
- t_start=500, t_target=300 → cur=300 at CFG; HOLD directly after the control write, with no WAIT.
- t_step=250, t_target=600, t_start=100 → values 350, 600 (saturated, never 850); 32-bit case t_target=0xFFFF_FFF0, step=0x20 → 0xFFFF_FFF0 with no wrap.
- Assert ls during WAIT → next cycle OFF; control write with wrdata[8]=0 and hv_code=0; fault=1. A following start clears fault.
- stop during CFG after the second write → remaining writes are skipped, OFF write issued, busy drops 2 cycles after stop.
- With PWM_RAMP_DOWN_EN, stop in HOLD at cur=400, start=100, step=100 → writes 300, 200, 100, then the OFF write.
